// File: rtl/ccsds123_pkg.sv
// Shared definitions for the CCSDS-123 packed-stream blocks.
//   DEF_BUS_WIDTH / DEF_MAX_LEN : default stream word and peek window widths
//   state_t                     : unpacker control state
//   byte_reverse()              : reorders the low nbytes bytes of a word so
//                                 that byte 0 ends up most significant
package ccsds123_pkg;

  localparam int DEF_BUS_WIDTH = 64;
  localparam int DEF_MAX_LEN   = 32;

  // Widest word byte_reverse() handles; callers cast down to their width.
  localparam int REV_MAX_W = 512;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic logic [REV_MAX_W-1:0] byte_reverse(
    input logic [REV_MAX_W-1:0] w,
    input int                   nbytes
  );
    logic [REV_MAX_W-1:0] r;
    logic [8:0]           src;
    logic [8:0]           dst;
    r = '0;
    for (int i = 0; i < REV_MAX_W / 8; i++) begin
      if (i < nbytes) begin
        src = 9'(8 * (nbytes - 1 - i));
        dst = 9'(8 * i);
        r[dst +: 8] = w[src +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ccsds123_bitbuf.sv
// Left-aligned bit buffer with fill tracking.
//   clk, areset : clock, asynchronous active-high reset
//   shift_len   : bits dropped from the oldest end this edge
//   insert      : append word (byte-reversed) behind the surviving bits
//   word        : raw stream word, byte 0 in bits 7:0
//   clear       : empty the buffer (overrides shift/insert)
//   peek_bits   : oldest MAX_LEN bits, oldest in the MSB
//   fill_q      : number of valid bits held
//   fill_next   : fill value that takes effect on the coming edge
module ccsds123_bitbuf
  import ccsds123_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int MAX_LEN   = DEF_MAX_LEN,
  parameter int LEN_W     = $clog2(MAX_LEN + 1),
  parameter int BUF_W     = MAX_LEN + BUS_WIDTH,
  parameter int FILL_W    = $clog2(BUF_W + 1)
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [LEN_W-1:0]     shift_len,
  input  logic                 insert,
  input  logic [BUS_WIDTH-1:0] word,
  input  logic                 clear,
  output logic [MAX_LEN-1:0]   peek_bits,
  output logic [FILL_W-1:0]    fill_q,
  output logic [FILL_W-1:0]    fill_next
);

  logic [BUF_W-1:0]     bits_q;
  logic [BUF_W-1:0]     bits_next;
  logic [BUS_WIDTH-1:0] rev_word;
  logic [FILL_W-1:0]    rem;
  logic [FILL_W-1:0]    ins_sh;
  logic [BUF_W-1:0]     ins_bits;

  assign rev_word = BUS_WIDTH'(byte_reverse(REV_MAX_W'(word), BUS_WIDTH / 8));

  // Bits surviving the consume; the new word lands directly behind them.
  // Inserts only happen with rem <= MAX_LEN, so ins_sh never underflows.
  assign rem      = fill_q - FILL_W'(shift_len);
  assign ins_sh   = FILL_W'(MAX_LEN) - rem;
  assign ins_bits = insert ? (BUF_W'(rev_word) << ins_sh) : '0;

  always_comb begin
    bits_next = '0;
    fill_next = '0;
    if (!clear) begin
      bits_next = (bits_q << shift_len) | ins_bits;
      fill_next = rem + (insert ? FILL_W'(BUS_WIDTH) : '0);
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      bits_q <= '0;
      fill_q <= '0;
    end else begin
      bits_q <= bits_next;
      fill_q <= fill_next;
    end
  end

  // Bits below fill are always zero, so the window needs no masking.
  assign peek_bits = bits_q[BUF_W-1 -: MAX_LEN];

endmodule

// File: rtl/ccsds123_bit_unpacker.sv
// Receive-side unpacker for the compressor's packed AXI-Stream output.
// Presents a left-aligned peek window of the next MAX_LEN stream bits that a
// downstream decoder consumes in variable-length chunks.
//   s_axis_*      : packed input stream, tlast marks the padded final word
//   peek_data     : next stream bits, oldest in the MSB, unused LSBs zero
//   peek_count    : valid bits in peek_data
//   peek_valid    : full window available, or frame remainder available
//   frame_end     : peek holds the whole remainder of the current frame
//   consume_*     : drop consume_len bits on the next edge
//   align         : discard the rest of the current frame
//   err           : sticky over-consume flag
//
// state | meaning
// FILL  | buffering the current frame, peek window live
// DRAIN | discarding words up to and including the next tlast word
module ccsds123_bit_unpacker
  import ccsds123_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int MAX_LEN   = DEF_MAX_LEN,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [BUS_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [MAX_LEN-1:0]   peek_data,
  output logic [LEN_W-1:0]     peek_count,
  output logic                 peek_valid,
  output logic                 frame_end,
  input  logic                 consume_valid,
  input  logic [LEN_W-1:0]     consume_len,
  input  logic                 align,
  output logic                 err
);

  localparam int BUF_W  = MAX_LEN + BUS_WIDTH;
  localparam int FILL_W = $clog2(BUF_W + 1);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              tready_q, tready_d;
  logic              err_q, err_d;
  logic [LEN_W-1:0]  shift_len;
  logic              insert;
  logic              clear;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_next;
  logic              accept;
  logic              accept_last;
  logic              consume_hit;
  logic              over;
  logic              in_fill;

  ccsds123_bitbuf #(
    .BUS_WIDTH (BUS_WIDTH),
    .MAX_LEN   (MAX_LEN),
    .LEN_W     (LEN_W),
    .BUF_W     (BUF_W),
    .FILL_W    (FILL_W)
  ) u_bitbuf (
    .clk       (clk),
    .areset    (areset),
    .shift_len (shift_len),
    .insert    (insert),
    .word      (s_axis_tdata),
    .clear     (clear),
    .peek_bits (peek_data),
    .fill_q    (fill_q),
    .fill_next (fill_next)
  );

  assign in_fill    = (state_q == FILL);
  assign peek_valid = in_fill && ((fill_q >= FILL_W'(MAX_LEN)) || (last_q && (fill_q != '0)));
  assign frame_end  = in_fill && last_q && (fill_q <= FILL_W'(MAX_LEN));
  assign peek_count = (fill_q >= FILL_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : LEN_W'(fill_q);

  assign accept      = s_axis_tvalid && tready_q;
  assign accept_last = accept && s_axis_tlast;
  assign consume_hit = consume_valid && peek_valid;
  assign over        = consume_hit && (consume_len > peek_count);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    err_d     = err_q;
    shift_len = '0;
    insert    = 1'b0;
    clear     = 1'b0;
    case (state_q)
      FILL: begin
        if (align) begin
          // A word accepted alongside align belongs to the abandoned frame;
          // if it carries tlast there is nothing left to drain.
          clear  = 1'b1;
          last_d = 1'b0;
          if (!last_q && !accept_last) state_d = DRAIN;
        end else if (over) begin
          clear = 1'b1;
          err_d = 1'b1;
        end else begin
          shift_len = consume_hit ? consume_len : '0;
          insert    = accept;
          if (accept_last) last_d = 1'b1;
        end
      end
      DRAIN: begin
        if (accept_last) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
    // Registered so tready never follows consume inputs combinationally.
    tready_d = (state_d == DRAIN) || ((fill_next <= FILL_W'(MAX_LEN)) && !last_d);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q  <= FILL;
      last_q   <= 1'b0;
      tready_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      tready_q <= tready_d;
      err_q    <= err_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ccsds123_bit_unpacker.sv
module tb_ccsds123_bit_unpacker;

  logic        clk = 1'b0;
  logic        areset;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] peek_data;
  logic [5:0]  peek_count;
  logic        peek_valid;
  logic        frame_end;
  logic        consume_valid;
  logic [5:0]  consume_len;
  logic        align;
  logic        err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  ccsds123_bit_unpacker dut (
    .clk           (clk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .peek_data     (peek_data),
    .peek_count    (peek_count),
    .peek_valid    (peek_valid),
    .frame_end     (frame_end),
    .consume_valid (consume_valid),
    .consume_len   (consume_len),
    .align         (align),
    .err           (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: the stream as a plain queue of bits, oldest first.
  bit mq[$];
  bit mlast, mdrain, merr, mtready;

  function automatic int mcount();
    return (mq.size() >= 32) ? 32 : mq.size();
  endfunction

  function automatic bit mvalid();
    return !mdrain && (mq.size() >= 32 || (mlast && mq.size() > 0));
  endfunction

  function automatic bit mframe_end();
    return !mdrain && mlast && mq.size() <= 32;
  endfunction

  function automatic logic [31:0] mpeek();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < mq.size()) r[31-i] = mq[i];
    return r;
  endfunction

  always @(posedge clk or posedge areset) begin
    bit acc;
    bit v;
    int c;
    if (areset) begin
      mq.delete();
      mlast = 0; mdrain = 0; merr = 0; mtready = 0;
    end else begin
      acc = s_axis_tvalid && mtready;
      v   = mvalid();
      if (mdrain) begin
        if (acc && s_axis_tlast) mdrain = 0;
      end else if (align) begin
        mq.delete();
        if (mlast) mlast = 0;
        else if (!(acc && s_axis_tlast)) mdrain = 1;
      end else begin
        c = (consume_valid && v) ? int'(consume_len) : 0;
        if (c > mcount()) begin
          merr = 1;
          mq.delete();
        end else begin
          for (int k = 0; k < c; k++) void'(mq.pop_front());
          if (acc) begin
            for (int b = 0; b < 8; b++)
              for (int k = 7; k >= 0; k--) mq.push_back(s_axis_tdata[8*b+k]);
            if (s_axis_tlast) mlast = 1;
          end
        end
      end
      mtready = mdrain || (mq.size() <= 32 && !mlast);
    end
  end

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en && !areset) begin
      check("m_peek_data",  peek_data,     mpeek());
      check("m_peek_count", peek_count,    mcount());
      check("m_peek_valid", peek_valid,    mvalid());
      check("m_frame_end",  frame_end,     mframe_end());
      check("m_tready",     s_axis_tready, mtready);
      check("m_err",        err,           merr);
    end
  end

  task automatic send(input logic [63:0] d, input bit last);
    s_axis_tdata  = d;
    s_axis_tvalid = 1;
    s_axis_tlast  = last;
    @(negedge clk);
    s_axis_tvalid = 0;
    s_axis_tlast  = 0;
  endtask

  task automatic consume(input int n);
    consume_valid = 1;
    consume_len   = 6'(n);
    @(negedge clk);
    consume_valid = 0;
    consume_len   = 0;
  endtask

  task automatic do_align();
    align = 1;
    @(negedge clk);
    align = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1; s_axis_tdata = '0; s_axis_tvalid = 0; s_axis_tlast = 0;
    consume_valid = 0; consume_len = 0; align = 0;
    repeat (2) @(negedge clk);
    check("rst_tready", s_axis_tready, 0);
    check("rst_peek_valid", peek_valid, 0);
    check("rst_peek_data", peek_data, 0);
    areset = 0;
    cmp_en = 1;
    @(negedge clk);
    check("first_tready", s_axis_tready, 1);

    // 1: basic peek and consume
    send(64'h0807060504030201, 0);
    check("t1_peek", peek_data, 32'h01020304);
    check("t1_count", peek_count, 32);
    check("t1_valid", peek_valid, 1);
    consume(4);
    check("t1_peek_after4", peek_data, 32'h10203040);
    do_align();
    check("t1_drain_valid", peek_valid, 0);
    check("t1_drain_tready", s_axis_tready, 1);
    send(64'hDEADBEEFDEADBEEF, 1);
    check("t1_back_tready", s_axis_tready, 1);

    // 2: final-word draining
    send(64'h8B77665544332211, 1);
    check("t2_peek", peek_data, 32'h11223344);
    check("t2_tready", s_axis_tready, 0);
    check("t2_fe_early", frame_end, 0);
    consume(32);
    check("t2_peek32", peek_data, 32'h5566778B);
    check("t2_fe32", frame_end, 1);
    consume(30);
    check("t2_count2", peek_count, 2);
    check("t2_peek2", peek_data, 32'hC0000000);
    check("t2_fe2", frame_end, 1);
    check("t2_valid2", peek_valid, 1);
    check("t2_tready2", s_axis_tready, 0);
    do_align();
    check("t2_align_count", peek_count, 0);
    check("t2_align_tready", s_axis_tready, 1);
    check("t2_align_fe", frame_end, 0);

    // 3: align mid-frame
    send(64'hAAAAAAAAAAAAAAAA, 0);
    check("t3_first_valid", peek_valid, 1);
    do_align();
    send(64'h1111111111111111, 0);
    check("t3_drop2_valid", peek_valid, 0);
    send(64'h2222222222222222, 1);
    check("t3_drop3_valid", peek_valid, 0);
    check("t3_drop3_tready", s_axis_tready, 1);
    send(64'hEFCDAB8967452301, 1);
    check("t3_next_peek", peek_data, 32'h01234567);
    check("t3_next_count", peek_count, 32);

    // 4: over-consume
    consume(32);
    check("t4_peek32", peek_data, 32'h89ABCDEF);
    consume(30);
    check("t4_count2", peek_count, 2);
    consume(5);
    check("t4_err", err, 1);
    check("t4_count0", peek_count, 0);
    check("t4_valid0", peek_valid, 0);
    repeat (2) @(negedge clk);
    check("t4_err_sticky", err, 1);
    do_align();
    send(64'h44332211BEBAFECA, 1);
    check("t4_new_peek", peek_data, 32'hCAFEBABE);
    check("t4_err_still", err, 1);
    consume(32);
    check("t4_new_peek2", peek_data, 32'h11223344);
    do_align();

    // 5: backpressure
    s_axis_tdata = 64'h0F0E0D0C0B0A0908; s_axis_tvalid = 1; s_axis_tlast = 0;
    @(negedge clk);
    check("t5_tready_full", s_axis_tready, 0);
    repeat (3) @(negedge clk);
    check("t5_tready_hold", s_axis_tready, 0);
    check("t5_peek_hold", peek_data, 32'h08090A0B);
    consume_valid = 1; consume_len = 32;
    @(negedge clk);
    consume_valid = 0; consume_len = 0;
    check("t5_tready_reopen", s_axis_tready, 1);
    check("t5_peek_after", peek_data, 32'h0C0D0E0F);
    @(negedge clk);
    s_axis_tvalid = 0;
    check("t5_tready_96", s_axis_tready, 0);
    check("t5_count_96", peek_count, 32);
    consume(32);
    consume(32);
    check("t5_peek_word2", peek_data, 32'h0C0D0E0F);
    consume(32);
    check("t5_tready_empty", s_axis_tready, 1);

    // 6: async reset mid-frame
    send(64'h7766554433221100, 0);
    @(posedge clk);
    #2;
    areset = 1;
    #1;
    check("t6_peek_data", peek_data, 0);
    check("t6_peek_count", peek_count, 0);
    check("t6_peek_valid", peek_valid, 0);
    check("t6_frame_end", frame_end, 0);
    check("t6_tready", s_axis_tready, 0);
    check("t6_err", err, 0);
    @(negedge clk);
    areset = 0;
    @(negedge clk);
    check("t6_first_tready", s_axis_tready, 1);
    send(64'hEFCDAB8967452301, 1);
    check("t6_peek", peek_data, 32'h01234567);
    check("t6_err_clear", err, 0);
    check("t6_fe", frame_end, 0);
    do_align();
    repeat (2) @(negedge clk);

    cmp_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
